clint_trap_ctrl: RTL
====================

// Module: clint_trap_ctrl
// PURPOSE
//  Parametrised core-local trap controller: NUM_IRQ external interrupt lines with pending latch, per-line enable and fixed priority.
//  Handles ECALL/EBREAK/MRET and sequences the mepc, mcause and mstatus CSR writes over successive cycles.
//  Then redirects fetch via int_assert_o/int_addr_o.
//  Sits between decode/execute and the CSR file; stalls the pipeline via hold_o while a trap sequence runs.
// PARAMETERS
//  NUM_IRQ        8   number of interrupt lines (1..16)
//  IRQ_CAUSE_BASE 16  mcause code of line 0; line k -> IRQ_CAUSE_BASE+k
//  CSR_ADDR_W     12  CSR address width
// PORTS
//  clk            in   1        clock
//  rst            in   1        asynchronous reset, active-high
//  irq_i          in   NUM_IRQ  interrupt lines, level; rising edge sets pending
//  irq_en_i       in   NUM_IRQ  per-line enable (mie image)
//  inst_i         in   32       instruction in execute
//  inst_addr_i    in   32       PC of inst_i
//  jump_flag_i    in   1        execute is redirecting this cycle
//  jump_addr_i    in   32       redirect target
//  stall_ex_i     in   1        execute busy (multicycle op); blocks async entry
//  csr_mtvec_i    in   32       mtvec
//  csr_mepc_i     in   32       mepc
//  csr_mstatus_i  in   32       mstatus
//  hold_o         out  1        pipeline hold
//  csr_we_o       out  1        CSR write strobe
//  csr_waddr_o    out  CSR_ADDR_W  CSR write address
//  csr_wdata_o    out  32       CSR write data
//  int_assert_o   out  1        one-cycle fetch redirect
//  int_addr_o     out  32       redirect target
//  irq_pending_o  out  NUM_IRQ  pending vector
// BEHAVIOUR
//  Reset: all outputs 0, pending 0, FSM IDLE; reset mid-sequence abandons it, no partial CSR write after release.
//  Pending: bit k set on 0->1 of irq_i[k]; cleared in the MEPC-write cycle of the trap that takes it; set wins over clear.
//  Entry (IDLE only), priority sync > mret > async:
//   sync : inst_i==32'h00000073 (cause 11) or 32'h00100073 (cause 3).
//   mret : inst_i==32'h30200073.
//   async: |(pending & irq_en_i) && mstatus[3] && !stall_ex_i; lowest set index wins, cause {1'b1, IRQ_CAUSE_BASE+k}.
//  States: IDLE -> W_MEPC -> W_MCAUSE -> W_MSTATUS -> ASSERT -> IDLE (trap).
//   mret: IDLE -> W_MSTATUS_MRET -> ASSERT -> IDLE.
//  hold_o=1 in every non-IDLE state; it is combinationally 1 in the IDLE cycle an entry is detected.
//  W_MEPC: waddr 0x341; data = inst_addr_i for sync (latched at entry).
//   For async: jump_addr_i if jump_flag_i, else inst_addr_i (latched at entry).
//  W_MCAUSE: 0x342, latched cause.
//  W_MSTATUS: 0x300, mstatus with bit7=old bit3, bit3=0.
//  W_MSTATUS_MRET: 0x300, bit3=old bit7, bit7=1.
//  ASSERT: int_assert_o=1 for exactly one cycle; int_addr_o = {mtvec[31:2],2'b00} for a trap, csr_mepc_i for mret.
//  csr_we_o=1 only in W_* states; addr/data 0 otherwise.
//  Latency: trap entry to int_assert_o = 4 cycles; mret = 2 cycles.
//  Lines arriving during a sequence stay pending; they are evaluated on return to IDLE.
// CONFIGURATION
//  CLINT_VECTORED_EN defined: if mtvec[1:0]==2'b01, async trap target is base + 4*(IRQ_CAUSE_BASE+k).
//   Sync traps always use base.
//  CLINT_VECTORED_EN undefined: mtvec[1:0] ignored, all traps go to base.
// TESTING
//  ECALL at PC 0x100, mtvec 0x800 -> writes 0x341=0x100, 0x342=11, 0x300 MIE->MPIE; int_assert_o 4 cycles later to 0x800.
//  irq_i=8'b0010_0100, all enabled, MIE=1 -> mcause 0x80000012 (line 2); line 5 stays pending, taken after MRET.
//  MRET with mepc 0x104, mstatus MPIE=1 -> 0x300 gets MIE=1/MPIE=1; assert to 0x104 after 2 cycles.
//  ECALL and enabled irq in same cycle -> sync taken first; irq_pending_o retains line; MIE=0 blocks it.
//  Vectored build, mtvec 0x801, irq line 3 -> int_addr_o=0x800+4*19=0x84C; non-vectored build -> 0x800.
//  rst pulsed during W_MCAUSE -> outputs 0 immediately, pending cleared, no further csr_we_o.

Source files
------------

// File: rtl/clint_trap_ctrl.sv
// clint_trap_ctrl: core-local trap controller.
// Latches rising edges of NUM_IRQ interrupt lines into a pending vector and
// picks the lowest enabled line. Handles ECALL/EBREAK/MRET. Writes mepc,
// mcause and mstatus one per cycle, then pulses a fetch redirect.
// Optional build macro CLINT_VECTORED_EN: vectored async targets when
// mtvec[1:0]==2'b01.
module clint_trap_ctrl #(
  parameter int NUM_IRQ        = 8,
  parameter int IRQ_CAUSE_BASE = 16,
  parameter int CSR_ADDR_W     = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_IRQ-1:0]    irq_i,
  input  logic [NUM_IRQ-1:0]    irq_en_i,
  input  logic [31:0]           inst_i,
  input  logic [31:0]           inst_addr_i,
  input  logic                  jump_flag_i,
  input  logic [31:0]           jump_addr_i,
  input  logic                  stall_ex_i,
  input  logic [31:0]           csr_mtvec_i,
  input  logic [31:0]           csr_mepc_i,
  input  logic [31:0]           csr_mstatus_i,
  output logic                  hold_o,
  output logic                  csr_we_o,
  output logic [CSR_ADDR_W-1:0] csr_waddr_o,
  output logic [31:0]           csr_wdata_o,
  output logic                  int_assert_o,
  output logic [31:0]           int_addr_o,
  output logic [NUM_IRQ-1:0]    irq_pending_o
);

  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [CSR_ADDR_W-1:0] A_MSTATUS = CSR_ADDR_W'(12'h300);
  localparam logic [CSR_ADDR_W-1:0] A_MEPC    = CSR_ADDR_W'(12'h341);
  localparam logic [CSR_ADDR_W-1:0] A_MCAUSE  = CSR_ADDR_W'(12'h342);

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MSTATUS,
    W_MSTATUS_MRET,
    ASSERT
  } state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] masked;
  logic [NUM_IRQ-1:0] clr;
  logic [31:0]        cause_q;
  logic               async_q;
  logic [IW-1:0]      idx_q;
  logic [IW-1:0]      idx;
  logic               is_sync;
  logic               is_mret;
  logic               async_hit;
  logic               entry;
  logic [31:0]        async_cause;
  logic [31:0]        trap_target;
  logic               unused_mtvec_mode;

  // Trap entry: MPIE <- MIE, MIE <- 0.
  function automatic logic [31:0] trap_mst(input logic [31:0] m);
    logic [31:0] r;
    r    = m;
    r[7] = m[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // MRET: MIE <- MPIE, MPIE <- 1.
  function automatic logic [31:0] mret_mst(input logic [31:0] m);
    logic [31:0] r;
    r    = m;
    r[3] = m[7];
    r[7] = 1'b1;
    return r;
  endfunction

  assign is_sync   = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);
  assign is_mret   = (inst_i == INST_MRET);
  assign masked    = pending & irq_en_i;
  assign async_hit = (|masked) && csr_mstatus_i[3] && !stall_ex_i;
  assign entry     = (state == IDLE) && (is_sync || is_mret || async_hit);

  // Hold is combinational so the entry cycle itself is already frozen.
  assign hold_o        = !rst && ((state != IDLE) || entry);
  assign irq_pending_o = pending;
  assign async_cause   = {1'b1, 31'(IRQ_CAUSE_BASE) + 31'(idx)};
  assign unused_mtvec_mode = ^csr_mtvec_i[1:0];

  // Lowest-index enabled pending line wins; scan downward so the lowest write sticks.
  always_comb begin
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (masked[i]) idx = IW'(i);
    end
  end

  // Redirect target for traps; vectored mode offsets async traps by 4*cause.
  always_comb begin
    trap_target = {csr_mtvec_i[31:2], 2'b00};
`ifdef CLINT_VECTORED_EN
    if (async_q && (csr_mtvec_i[1:0] == 2'b01))
      trap_target = trap_target + {cause_q[29:0], 2'b00};
`else
`endif
  end

  // Pending bit of the taken line drops in its mepc-write cycle.
  always_comb begin
    clr = '0;
    if ((state == W_MEPC) && async_q) clr[idx_q] = 1'b1;
  end

  // Edge detect into the pending latch; a new edge beats the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q   <= '0;
      pending <= '0;
    end else begin
      irq_q   <= irq_i;
      pending <= (pending & ~clr) | (irq_i & ~irq_q);
    end
  end

  // Trap sequencer with registered CSR-write and redirect outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cause_q      <= '0;
      async_q      <= 1'b0;
      idx_q        <= '0;
      csr_we_o     <= 1'b0;
      csr_waddr_o  <= '0;
      csr_wdata_o  <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
    end else begin
      csr_we_o     <= 1'b0;
      csr_waddr_o  <= '0;
      csr_wdata_o  <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
      case (state)
        IDLE: begin
          if (is_sync) begin
            state       <= W_MEPC;
            cause_q     <= (inst_i == INST_ECALL) ? 32'd11 : 32'd3;
            async_q     <= 1'b0;
            csr_we_o    <= 1'b1;
            csr_waddr_o <= A_MEPC;
            csr_wdata_o <= inst_addr_i;
          end else if (is_mret) begin
            state       <= W_MSTATUS_MRET;
            csr_we_o    <= 1'b1;
            csr_waddr_o <= A_MSTATUS;
            csr_wdata_o <= mret_mst(csr_mstatus_i);
          end else if (async_hit) begin
            state       <= W_MEPC;
            cause_q     <= async_cause;
            async_q     <= 1'b1;
            idx_q       <= idx;
            csr_we_o    <= 1'b1;
            csr_waddr_o <= A_MEPC;
            csr_wdata_o <= jump_flag_i ? jump_addr_i : inst_addr_i;
          end
        end
        W_MEPC: begin
          state       <= W_MCAUSE;
          csr_we_o    <= 1'b1;
          csr_waddr_o <= A_MCAUSE;
          csr_wdata_o <= cause_q;
        end
        W_MCAUSE: begin
          state       <= W_MSTATUS;
          csr_we_o    <= 1'b1;
          csr_waddr_o <= A_MSTATUS;
          csr_wdata_o <= trap_mst(csr_mstatus_i);
        end
        W_MSTATUS: begin
          state        <= ASSERT;
          int_assert_o <= 1'b1;
          int_addr_o   <= trap_target;
        end
        W_MSTATUS_MRET: begin
          state        <= ASSERT;
          int_assert_o <= 1'b1;
          int_addr_o   <= csr_mepc_i;
        end
        ASSERT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
